// File: rtl/lsu_dm_port.sv
// lsu_dm_port -- load/store unit, processor-side initiator for the data memory.
//
// Turns one core load/store request into a single byte-enabled word access.
// Store data is lane-replicated. Load data is shifted down to bit 0 and then
// sign- or zero-extended. The core is stalled while the access is in flight.
//
// FSM: IDLE -> ACCESS -> RESP. An illegal request goes straight to RESP with
// the error flag set and never touches memory. A request is accepted in IDLE
// or RESP, so back-to-back accesses complete one every two cycles.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/W accesses are rejected (err=1, no memory cycle)
//   undefined : misaligned H/W accesses are aligned down and performed normally
//
// Ports
//   clk_i, rst_n_i   clock (rising edge), asynchronous active-low reset
//   lsu_req_i        core access request
//   lsu_we_i         1 = store, 0 = load
//   lsu_size_i       RV32I funct3 (B, H, W, BU, HU)
//   lsu_addr_i       byte address
//   lsu_data_i       right-aligned store data
//   lsu_stall_o      core must hold its pipeline
//   lsu_valid_o      one-cycle completion pulse
//   lsu_data_o       extended load result (0 for stores / when not valid)
//   lsu_err_o        illegal size or misaligned (with valid)
//   mem_addr_o       word address to memory
//   mem_be_o         byte-lane enables
//   mem_wd_o         lane-replicated write data
//   mem_we_o         write strobe (one cycle)
//   mem_rd_i         read word, combinational from mem_addr_o
module lsu_dm_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic              lsu_stall_o,
  output logic              lsu_valid_o,
  output logic [DATA_W-1:0] lsu_data_o,
  output logic              lsu_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wd_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t state_q, state_d;

  // Request captured on accept (stage 1) and the response (stage 2).
  logic [ADDR_W-1:0] addr_p1;
  logic [2:0]        size_p1;
  logic              we_p1;
  logic [DATA_W-1:0] wdat_p1;
  logic [DATA_W-1:0] rslt_p2;
  logic              err_p2;

  logic              accept;
  logic              in_access;
  logic              size_ok;
  logic              misaligned;
  logic              req_bad;

  // Aligns H down to a halfword and W down to a word boundary.
  function automatic logic [ADDR_W-1:0] legalize(input logic [ADDR_W-1:0] a,
                                                 input logic [2:0] sz);
    logic [ADDR_W-1:0] r;
    r = a;
    if (sz[1:0] == 2'b01) r[0] = 1'b0;
    if (sz[1:0] == 2'b10) r[1:0] = 2'b00;
    return r;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] lane_wd(input logic [2:0] sz,
                                               input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] wd;
    case (sz[1:0])
      2'b00:   wd = {4{d[7:0]}};
      2'b01:   wd = {2{d[15:0]}};
      default: wd = d;
    endcase
    return wd;
  endfunction

  // Shift the addressed bytes down to bit 0, then extend by funct3.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] word,
                                                input logic [2:0] sz,
                                                input logic [1:0] off);
    logic [DATA_W-1:0] sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    logic signed [DATA_W-1:0] ext;
    sh  = word >> {off, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    case (sz)
      3'b000:  ext = DATA_W'(sb);
      3'b001:  ext = DATA_W'(shw);
      3'b100:  ext = {24'd0, sh[7:0]};
      3'b101:  ext = {16'd0, sh[15:0]};
      default: ext = sh;
    endcase
    return ext;
  endfunction

  always_comb begin
    size_ok = (lsu_size_i == 3'b000) || (lsu_size_i == 3'b001) ||
              (lsu_size_i == 3'b010) || (lsu_size_i == 3'b100) ||
              (lsu_size_i == 3'b101);
    misaligned = ((lsu_size_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                 ((lsu_size_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    req_bad = !size_ok || misaligned;
`else
    req_bad = !size_ok;
`endif
  end

  assign in_access = (state_q == ACCESS);
  assign accept    = lsu_req_i && !in_access;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) state_d = req_bad ? RESP : ACCESS;
        else        state_d = IDLE;
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Stage 1: capture the request on accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_p1 <= '0;
      size_p1 <= '0;
      we_p1   <= 1'b0;
      wdat_p1 <= '0;
    end else if (accept) begin
      addr_p1 <= legalize(lsu_addr_i, lsu_size_i);
      size_p1 <= lsu_size_i;
      we_p1   <= lsu_we_i;
      wdat_p1 <= lsu_data_i;
    end
  end

  // Stage 2: response; an illegal accept writes the error result directly.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rslt_p2 <= '0;
      err_p2  <= 1'b0;
    end else if (in_access) begin
      rslt_p2 <= we_p1 ? '0 : load_ext(mem_rd_i, size_p1, addr_p1[1:0]);
      err_p2  <= 1'b0;
    end else if (accept) begin
      rslt_p2 <= '0;
      err_p2  <= req_bad;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wd_o    = '0;
    mem_we_o    = 1'b0;
    if (in_access) begin
      mem_addr_o = {addr_p1[ADDR_W-1:2], 2'b00};
      mem_be_o   = lane_be(size_p1, addr_p1[1:0]);
      mem_wd_o   = lane_wd(size_p1, wdat_p1);
      mem_we_o   = we_p1;
    end
    lsu_valid_o = (state_q == RESP);
    lsu_data_o  = lsu_valid_o ? rslt_p2 : '0;
    lsu_err_o   = lsu_valid_o ? err_p2  : 1'b0;
    // Gated by reset so every output reads 0 while reset is held.
    lsu_stall_o = rst_n_i && ((lsu_req_i && !in_access) || in_access);
  end

endmodule

// File: tb/tb_lsu_dm_port.sv
module tb_lsu_dm_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [2:0]  size;
  logic [31:0] addr, wdata;
  logic        stall, valid, err, mwe;
  logic [31:0] rdata, maddr, mwd, mrd;
  logic [3:0]  mbe;

  always #5 clk = ~clk;

  lsu_dm_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(size),
    .lsu_addr_i(addr), .lsu_data_i(wdata),
    .lsu_stall_o(stall), .lsu_valid_o(valid), .lsu_data_o(rdata), .lsu_err_o(err),
    .mem_addr_o(maddr), .mem_be_o(mbe), .mem_wd_o(mwd), .mem_we_o(mwe),
    .mem_rd_i(mrd)
  );

  // Memory environment: 64 words, combinational read, byte-enabled write.
  logic [31:0] tb_mem [64];
  assign mrd = tb_mem[maddr[7:2]];

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) tb_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mwe)
        for (int j = 0; j < 4; j++)
          if (mbe[j]) tb_mem[maddr[7:2]][8*j +: 8] = mwd[8*j +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: flat byte memory.
  logic [7:0] ref_b [256];

  typedef struct { logic [31:0] data; logic err; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic we; int cyc; } mem_t;
  rsp_t rsp_q[$];
  mem_t mem_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_illegal(input logic [2:0] sz, input logic [31:0] a);
    if (sz == 3'd3 || sz >= 3'd6) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz[1:0] == 2'b01 && a[0]) return 1'b1;
    if (sz[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic monitor();
    rsp_t r;
    mem_t m;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (valid) begin
          if (rsp_q.size() == 0) chk("unexpected_valid", 32'(valid), 32'd0);
          else begin
            r = rsp_q.pop_front();
            chk("rsp_data", rdata, r.data);
            chk("rsp_err", 32'(err), 32'(r.err));
            chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
          end
        end else begin
          chk("idle_data_err", {rdata[30:0], err}, 32'd0);
        end
        if (mbe != 4'd0 || mwe) begin
          if (mem_q.size() == 0) chk("unexpected_mem_cycle", {27'd0, mwe, mbe}, 32'd0);
          else begin
            m = mem_q.pop_front();
            chk("mem_addr", maddr, m.addr);
            chk("mem_be", 32'(mbe), 32'(m.be));
            chk("mem_we", 32'(mwe), 32'(m.we));
            if (m.we) chk("mem_wd", mwd, m.wd);
            chk("mem_cycle", 32'(cyc), 32'(m.cyc));
          end
        end
      end
    end
  endtask

  task automatic issue(input logic we_v, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    bit          bad;
    int          nb;
    logic [31:0] eff, val, mask;
    logic [3:0]  be;
    logic [31:0] wd;
    int          acc;
    @(negedge clk);
    req = 1'b1; we = we_v; size = sz; addr = a; wdata = d;
    #1 chk("stall_on_req", 32'(stall), 32'd1);
    bad  = is_illegal(sz, a);
    nb   = 1 << sz[1:0];
    eff  = a & ~(32'(nb) - 32'd1);
    val  = 32'd0;
    be   = 4'd0;
    wd   = 32'd0;
    if (!bad) begin
      for (int i = 0; i < nb; i++) be[eff[1:0] + i] = 1'b1;
      for (int j = 0; j < 4; j++) wd[8*j +: 8] = d[8*(j % nb) +: 8];
      if (we_v) begin
        for (int i = 0; i < nb; i++) ref_b[eff + 32'(i)] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) val = val | (32'(ref_b[eff + 32'(i)]) << (8*i));
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
        if (!sz[2] && nb < 4 && val[8*nb-1]) val = val | ~mask;
      end
    end
    @(posedge clk);
    #1 acc = cyc;
    rsp_q.push_back('{data: val, err: bad, cyc: bad ? acc : acc + 1});
    if (!bad) begin
      mem_q.push_back('{addr: {eff[31:2], 2'b00}, be: be, wd: wd, we: we_v, cyc: acc});
      @(negedge clk);
      chk("stall_in_access", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0;
    #1 chk("stall_idle", 32'(stall), 32'd0);
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 3'b010; addr = 32'h10; wdata = 32'd0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid_err", {30'd0, valid, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem", {27'd0, mwe, mbe}, 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_mwd", mwd, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_valid", 32'(valid), 32'd0);
    chk("post_rst_mem", 32'(mbe), 32'd0);
  endtask

  initial begin
    logic [2:0] sizes [13];
    int         k;
    sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 64; i++)
      for (int b = 0; b < 4; b++) ref_b[4*i + b] = init_word(i) >> (8*b);
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 3'd0; addr = 32'd0; wdata = 32'd0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {25'd0, stall, valid, err, mwe, mbe != 4'd0, maddr != 0, rdata != 0}, 32'd0);
    rst_n = 1'b1;

    // Directed cases.
    issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h8, 32'h0);
    idle();
    issue(1'b1, 3'b000, 32'h9, 32'h00000080);
    issue(1'b0, 3'b000, 32'h9, 32'h0);
    issue(1'b0, 3'b100, 32'h9, 32'h0);
    idle();
    issue(1'b1, 3'b001, 32'hA, 32'h00008001);
    issue(1'b0, 3'b001, 32'hA, 32'h0);
    issue(1'b0, 3'b101, 32'hA, 32'h0);
    idle();
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    issue(1'b0, 3'b010, 32'h24, 32'h0);
    issue(1'b0, 3'b010, 32'h28, 32'h0);
    idle();
    issue(1'b0, 3'b010, 32'h6, 32'h0);
    issue(1'b0, 3'b011, 32'h4, 32'h0);
    issue(1'b1, 3'b111, 32'h4, 32'h12345678);
    issue(1'b0, 3'b001, 32'h13, 32'h0);
    idle();

    reset_mid_access();
    issue(1'b0, 3'b010, 32'h10, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      k = $urandom_range(0, 12);
      issue(1'($urandom_range(0, 1)), sizes[k], 32'($urandom_range(0, 255)), $urandom);
    end
    idle();

    for (int w = 0; w < 20; w++) begin
      if (rsp_q.size() == 0 && mem_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain_rsp", 32'(rsp_q.size()), 32'd0);
    chk("drain_mem", 32'(mem_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
